// File: rtl/direct_sound_scheduler_pkg.sv
// Shared Direct Sound scheduler types and constants: arbiter states, FIFO sizing,
// SOUNDCNT_H bit positions.
package direct_sound_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_A = 2'd1,
        REQ_B = 2'd2,
        BURST = 2'd3
    } ds_sched_state_t;

    localparam int unsigned DS_FIFO_DEPTH_WORDS = 8;
    localparam int unsigned DS_REQ_THRESHOLD    = 4;
    localparam int unsigned DS_BURST_WORDS      = 4;

    localparam int unsigned DS_SCNT_A_RIGHT_BIT = 8;
    localparam int unsigned DS_SCNT_A_LEFT_BIT  = 9;
    localparam int unsigned DS_SCNT_A_TIMER_BIT = 10;
    localparam int unsigned DS_SCNT_A_RST_BIT   = 11;
    localparam int unsigned DS_SCNT_B_RIGHT_BIT = 12;
    localparam int unsigned DS_SCNT_B_LEFT_BIT  = 13;
    localparam int unsigned DS_SCNT_B_TIMER_BIT = 14;
    localparam int unsigned DS_SCNT_B_RST_BIT   = 15;

    // Level registers are 4 bits wide; narrow integer constants to that width.
    function automatic logic [3:0] ds_level_const(input int unsigned v);
        return v[3:0];
    endfunction

endpackage

// File: rtl/direct_sound_scheduler_fifo_tracker.sv
// Per-FIFO sequencing: timer tick gating, byte-lane index, word level counter.
// Optional sticky underrun/overflow flags when DS_STATUS_EN is defined.
module ds_fifo_tracker
    import direct_sound_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DS_FIFO_DEPTH_WORDS
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_timer0_ovf,
    input  logic       i_timer1_ovf,
    input  logic       i_timer_sel,
    input  logic       i_enable,
    input  logic       i_fifo_rst,
    input  logic       i_fifo_wr,
`ifdef DS_STATUS_EN
    input  logic       i_status_clr,
    output logic       o_underrun,
    output logic       o_overflow,
`endif
    output logic       o_pop,
    output logic [3:0] o_level,
    output logic [1:0] o_sample_idx
);

    localparam logic [3:0] LVL_FULL = ds_level_const(DEPTH_WORDS);

    logic       r_pop;
    logic [3:0] r_level;
    logic [1:0] r_idx;

    logic w_tick;
    logic w_empty;
    logic w_full;
    logic w_adv;
    logic w_consume;

    assign w_tick    = i_enable & (i_timer_sel ? i_timer1_ovf : i_timer0_ovf);
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_FULL);
    assign w_adv     = w_tick & ~w_empty;
    assign w_consume = w_adv & (r_idx == 2'd3);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pop   <= 1'b0;
            r_level <= '0;
            r_idx   <= '0;
        end else if (i_fifo_rst) begin
            r_pop   <= 1'b0;
            r_level <= '0;
            r_idx   <= '0;
        end else begin
            r_pop <= w_adv;
            if (w_adv) begin
                r_idx <= r_idx + 2'd1;
            end
            // Write and consume together cancel out, so only the lone cases move the level.
            case ({i_fifo_wr, w_consume})
                2'b10:   if (!w_full) r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef DS_STATUS_EN
    logic r_underrun;
    logic r_overflow;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_status_clr) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tick && w_empty) r_underrun <= 1'b1;
            if (i_fifo_wr && w_full && !w_consume) r_overflow <= 1'b1;
        end
    end

    assign o_underrun = r_underrun;
    assign o_overflow = r_overflow;
`endif

    assign o_pop        = r_pop;
    assign o_level      = r_level;
    assign o_sample_idx = r_idx;

endmodule

// File: rtl/direct_sound_scheduler.sv
// Direct Sound A/B sample sequencing and round-robin refill DMA arbitration.
// Define DS_STATUS_EN to add sticky underrun/overflow flags and status_clr.
module direct_sound_scheduler
    import direct_sound_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_WORDS = DS_FIFO_DEPTH_WORDS,
    parameter int unsigned REQ_THRESHOLD    = DS_REQ_THRESHOLD,
    parameter int unsigned BURST_WORDS      = DS_BURST_WORDS
) (
    input  logic       clk_100,
    input  logic       reset_n,
    input  logic       timer0_ovf,
    input  logic       timer1_ovf,
    input  logic       timer_sel_a,
    input  logic       timer_sel_b,
    input  logic       enable_a,
    input  logic       enable_b,
    input  logic       fifo_rst_a,
    input  logic       fifo_rst_b,
    input  logic       fifo_wr_a,
    input  logic       fifo_wr_b,
    input  logic       dma_ack,
`ifdef DS_STATUS_EN
    input  logic       status_clr,
    output logic       underrun_a,
    output logic       underrun_b,
    output logic       overflow_a,
    output logic       overflow_b,
`endif
    output logic       pop_a,
    output logic       pop_b,
    output logic       sound_req1,
    output logic       sound_req2,
    output logic [3:0] level_a,
    output logic [3:0] level_b,
    output logic [1:0] sample_idx_a,
    output logic [1:0] sample_idx_b
);

    localparam logic [3:0]       LVL_THR  = ds_level_const(REQ_THRESHOLD);
    localparam int unsigned      CNT_W    = $clog2(BURST_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ds_fifo_tracker #(.DEPTH_WORDS(FIFO_DEPTH_WORDS)) u_trk_a (
        .i_clk        (clk_100),
        .i_reset_n    (reset_n),
        .i_timer0_ovf (timer0_ovf),
        .i_timer1_ovf (timer1_ovf),
        .i_timer_sel  (timer_sel_a),
        .i_enable     (enable_a),
        .i_fifo_rst   (fifo_rst_a),
        .i_fifo_wr    (fifo_wr_a),
`ifdef DS_STATUS_EN
        .i_status_clr (status_clr),
        .o_underrun   (underrun_a),
        .o_overflow   (overflow_a),
`endif
        .o_pop        (pop_a),
        .o_level      (level_a),
        .o_sample_idx (sample_idx_a)
    );

    ds_fifo_tracker #(.DEPTH_WORDS(FIFO_DEPTH_WORDS)) u_trk_b (
        .i_clk        (clk_100),
        .i_reset_n    (reset_n),
        .i_timer0_ovf (timer0_ovf),
        .i_timer1_ovf (timer1_ovf),
        .i_timer_sel  (timer_sel_b),
        .i_enable     (enable_b),
        .i_fifo_rst   (fifo_rst_b),
        .i_fifo_wr    (fifo_wr_b),
`ifdef DS_STATUS_EN
        .i_status_clr (status_clr),
        .o_underrun   (underrun_b),
        .o_overflow   (overflow_b),
`endif
        .o_pop        (pop_b),
        .o_level      (level_b),
        .o_sample_idx (sample_idx_b)
    );

    logic            r_need_a;
    logic            r_need_b;
    ds_sched_state_t r_state;
    logic            r_ptr_b;
    logic            r_gnt_b;
    logic [CNT_W-1:0] r_cnt;
    logic            r_req1;
    logic            r_req2;

    logic w_gnt_abort;
    logic w_gnt_wr;

    assign w_gnt_abort = r_gnt_b ? (fifo_rst_b | ~enable_b) : (fifo_rst_a | ~enable_a);
    assign w_gnt_wr    = r_gnt_b ? fifo_wr_b : fifo_wr_a;

    // A reset FIFO masks its need for one cycle so the arbiter sees the post-reset level.
    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            r_need_a <= 1'b0;
            r_need_b <= 1'b0;
        end else begin
            r_need_a <= enable_a & ~fifo_rst_a & (level_a <= LVL_THR);
            r_need_b <= enable_b & ~fifo_rst_b & (level_b <= LVL_THR);
        end
    end

    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr_b <= 1'b0;
            r_gnt_b <= 1'b0;
            r_cnt   <= '0;
            r_req1  <= 1'b0;
            r_req2  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_need_a && r_need_b) begin
                        r_ptr_b <= ~r_ptr_b;
                        r_gnt_b <= r_ptr_b;
                        if (r_ptr_b) begin
                            r_state <= REQ_B;
                            r_req2  <= 1'b1;
                        end else begin
                            r_state <= REQ_A;
                            r_req1  <= 1'b1;
                        end
                    end else if (r_need_a) begin
                        r_gnt_b <= 1'b0;
                        r_state <= REQ_A;
                        r_req1  <= 1'b1;
                    end else if (r_need_b) begin
                        r_gnt_b <= 1'b1;
                        r_state <= REQ_B;
                        r_req2  <= 1'b1;
                    end
                end
                REQ_A: begin
                    if (fifo_rst_a || !enable_a) begin
                        r_state <= IDLE;
                        r_req1  <= 1'b0;
                    end else if (dma_ack) begin
                        r_state <= BURST;
                        r_req1  <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                REQ_B: begin
                    if (fifo_rst_b || !enable_b) begin
                        r_state <= IDLE;
                        r_req2  <= 1'b0;
                    end else if (dma_ack) begin
                        r_state <= BURST;
                        r_req2  <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                BURST: begin
                    if (w_gnt_abort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_gnt_wr) begin
                        if (r_cnt == CNT_ONE) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sound_req1 = r_req1;
    assign sound_req2 = r_req2;

endmodule

// File: doc/direct_sound_scheduler.md
Name: direct_sound_scheduler

Overview:
- Sequences the two Direct Sound FIFOs (A and B): decides when each FIFO advances to its next 8-bit sample, and tracks FIFO occupancy in 32-bit words.
- Arbitrates the single shared refill DMA path between A and B, driving sound_req1/sound_req2 toward the DMA controller.
- Sits between the timer block, the SOUNDCNT_H control bits, and the two direct_sound datapath instances in the audio top level.

Parameters:
- FIFO_DEPTH_WORDS, 8: FIFO capacity in 32-bit words (32 samples).
- REQ_THRESHOLD, 4: request a refill when the word level is at or below this value.
- BURST_WORDS, 4: words delivered per granted DMA burst.

Ports:
- clk_100  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- timer0_ovf  in  1  one-cycle pulse on timer 0 overflow.
- timer1_ovf  in  1  one-cycle pulse on timer 1 overflow.
- timer_sel_a  in  1  timer select for A (SOUNDCNT_H bit 10): 0=timer0, 1=timer1.
- timer_sel_b  in  1  timer select for B (SOUNDCNT_H bit 14).
- enable_a  in  1  A routed to L or R (OR of SOUNDCNT_H bits 9:8).
- enable_b  in  1  B routed to L or R (OR of bits 13:12).
- fifo_rst_a  in  1  pulse on write of SOUNDCNT_H bit 11.
- fifo_rst_b  in  1  pulse on write of SOUNDCNT_H bit 15.
- fifo_wr_a  in  1  one word written to FIFO_A (CPU or DMA).
- fifo_wr_b  in  1  one word written to FIFO_B.
- dma_ack  in  1  DMA accepted the current request; burst follows.
- pop_a  out  1  one-cycle pulse: direct_sound A advances one sample.
- pop_b  out  1  one-cycle pulse: direct_sound B advances one sample.
- sound_req1  out  1  refill request for FIFO A.
- sound_req2  out  1  refill request for FIFO B.
- level_a  out  4  A occupancy in words, 0..FIFO_DEPTH_WORDS.
- level_b  out  4  B occupancy in words.
- sample_idx_a  out  2  byte lane of the current A sample.
- sample_idx_b  out  2  byte lane of the current B sample.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, FSM in IDLE, round-robin pointer set to A.
- Sample sequencing, per FIFO X:
  - tick_X is the overflow of the selected timer, gated by enable_X.
  - tick_X with level_X>0: pop_X=1 on the next cycle and sample_idx_X increments.
  - When sample_idx_X wraps 3->0, level_X decrements by 1 (word consumed).
  - tick_X with level_X==0: no pop, no index change (underrun).
- Writes:
  - fifo_wr_X increments level_X, saturating at FIFO_DEPTH_WORDS; writes to a full FIFO are dropped.
  - A write and a word-consume in the same cycle leave level_X unchanged.
- fifo_rst_X: next cycle level_X=0, sample_idx_X=0, pop_X suppressed. fifo_rst_X has priority over a same-cycle write or tick.
- need_X = enable_X and level_X <= REQ_THRESHOLD, evaluated on registered levels.
- FSM states:
  - IDLE:
    - If exactly one need_X, go to REQ_X.
    - If both, grant the round-robin pointer's FIFO, then flip the pointer.
  - REQ_A / REQ_B:
    - The matching sound_req is held high. Requests are level, never pulsed.
    - On dma_ack, go to BURST with the word counter = BURST_WORDS.
  - BURST:
    - The request is dropped.
    - Each fifo_wr of the granted FIFO decrements the counter; at 0, go to IDLE.
    - Writes to the non-granted FIFO still update its level.
- Latency:
  - Level crossing the threshold -> sound_req high 2 cycles later (1 cycle register, 1 cycle FSM).
  - In IDLE, a new request can issue the cycle after BURST ends.
- Abort on fifo_rst or enable drop of the granted FIFO:
  - In REQ_X: go to IDLE next cycle and drop the request.
  - In BURST: go to IDLE and discard remaining count.
- A need that disappears before ack (level refilled by CPU) does not withdraw the request; only fifo_rst or enable drop aborts.
- Simultaneous timer0_ovf and timer1_ovf are both honoured independently.

Optional Feature:
- Macro: DS_STATUS_EN.
- When defined, adds outputs:
  - underrun_a, underrun_b: sticky, set on tick at level 0.
  - overflow_a, overflow_b: sticky, set on write at full.
  - status_clr input: clears all sticky flags; clear wins over a same-cycle set.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared audio package holds:
  - enum ds_sched_state_t {IDLE, REQ_A, REQ_B, BURST}.
  - Constants DS_FIFO_DEPTH_WORDS=8, DS_REQ_THRESHOLD=4, DS_BURST_WORDS=4.
  - SOUNDCNT_H bit-position constants.
- One natural sub-module, ds_fifo_tracker, instantiated twice. It holds tick gating, sample index, level counter and reset/saturation rules.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset, then sel_a=0, enable_a=1, 5 writes to A, 4 timer0_ovf pulses:
  - level_a goes 5 -> 4.
  - Exactly 4 pop_a pulses, sample_idx_a back to 0.
  - No sound_req1 until level_a=4; sound_req1 high 2 cycles after it reaches 4.
- Both FIFOs at level 2, both enabled:
  - sound_req1 first, held until dma_ack.
  - 4 A writes complete the burst, then sound_req2 next.
  - Pointer alternation verified over 3 rounds.
- level_a=0 with timer pulses:
  - No pop_a, level stays 0.
  - With DS_STATUS_EN, underrun_a=1 until status_clr.
- 9 writes to empty A: level_a saturates at 8, ninth write dropped (overflow_a=1 with DS_STATUS_EN).
- In BURST for A after 2 writes, pulse fifo_rst_a:
  - level_a=0, FSM IDLE.
  - Next cycle need_a re-evaluates; sound_req1 re-asserts 2 cycles later.
- Same cycle: fifo_wr_b and a tick consuming B's last byte lane: level_b unchanged, pop_b pulses, sample_idx_b=0.
